// File: rtl/reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_wb_arbiter
// Description : Two-port writeback arbiter for the register file write port.
//               Port 1 has fixed priority; a starvation guard forces port 0
//               to win after STARVE_LIMIT consecutive losses.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_hold,
    input  logic            i_p0_valid,
    output logic            o_p0_ready,
    input  logic [4:0]      i_p0_rd,
    input  logic [XLEN-1:0] i_p0_data,
    input  logic            i_p1_valid,
    output logic            o_p1_ready,
    input  logic [4:0]      i_p1_rd,
    input  logic [XLEN-1:0] i_p1_data,
    output logic            o_wr,
    output logic [4:0]      o_rd,
    output logic [XLEN-1:0] o_write_data,
    output logic            o_src
);

    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [3:0] r_starve_cnt;
    logic       w_starved;
    logic       w_grant0;
    logic       w_grant1;
    logic       w_xfer0;
    logic       w_xfer1;

    // Port 1 wins contention unless port 0 has already lost STARVE_LIMIT times.
    assign w_starved = (r_starve_cnt == c_starve_limit);
    assign w_grant1  = i_p1_valid & ~(i_p0_valid & w_starved);
    assign w_grant0  = i_p0_valid & ~w_grant1;

    assign o_p0_ready = w_grant0 & ~i_hold & ~rst;
    assign o_p1_ready = w_grant1 & ~i_hold & ~rst;
    assign w_xfer0    = i_p0_valid & o_p0_ready;
    assign w_xfer1    = i_p1_valid & o_p1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (i_hold) begin
            r_starve_cnt <= r_starve_cnt;
        end else if (w_xfer0 || !i_p0_valid) begin
            r_starve_cnt <= 4'd0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_wr         <= 1'b0;
            o_rd         <= 5'd0;
            o_write_data <= '0;
            o_src        <= 1'b0;
        end else if (w_xfer1) begin
            o_wr         <= (i_p1_rd != 5'd0);
            o_rd         <= i_p1_rd;
            o_write_data <= i_p1_data;
            o_src        <= 1'b1;
        end else if (w_xfer0) begin
            o_wr         <= (i_p0_rd != 5'd0);
            o_rd         <= i_p0_rd;
            o_write_data <= i_p0_data;
            o_src        <= 1'b0;
        end else begin
            o_wr         <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_wb_arbiter
// Description : Directed self-checking bench for reg_wb_arbiter with an
//               expected-output scoreboard queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_wb_arbiter;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_hold;
    logic            i_p0_valid;
    logic            o_p0_ready;
    logic [4:0]      i_p0_rd;
    logic [XLEN-1:0] i_p0_data;
    logic            i_p1_valid;
    logic            o_p1_ready;
    logic [4:0]      i_p1_rd;
    logic [XLEN-1:0] i_p1_data;
    logic            o_wr;
    logic [4:0]      o_rd;
    logic [XLEN-1:0] o_write_data;
    logic            o_src;

    typedef struct packed {
        logic            wr;
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            src;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   checks = 0;
    int   errors = 0;

    reg_wb_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_hold       (i_hold),
        .i_p0_valid   (i_p0_valid),
        .o_p0_ready   (o_p0_ready),
        .i_p0_rd      (i_p0_rd),
        .i_p0_data    (i_p0_data),
        .i_p1_valid   (i_p1_valid),
        .o_p1_ready   (o_p1_ready),
        .i_p1_rd      (i_p1_rd),
        .i_p1_data    (i_p1_data),
        .o_wr         (o_wr),
        .o_rd         (o_rd),
        .o_write_data (o_write_data),
        .o_src        (o_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: check readies mid-cycle, queue the expected output, then
    // compare the registered outputs just after the following edge.
    task automatic cycle(input string tag, input logic er0, input logic er1);
        exp_t e;
        @(negedge clk);
        check({tag, ".p0_ready"}, 64'(o_p0_ready), 64'(er0));
        check({tag, ".p1_ready"}, 64'(o_p1_ready), 64'(er1));
        if (rst)
            e = '0;
        else if (er1 && i_p1_valid)
            e = '{wr: (i_p1_rd != 5'd0), rd: i_p1_rd, data: i_p1_data, src: 1'b1};
        else if (er0 && i_p0_valid)
            e = '{wr: (i_p0_rd != 5'd0), rd: i_p0_rd, data: i_p0_data, src: 1'b0};
        else
            e = '{wr: 1'b0, rd: last.rd, data: last.data, src: last.src};
        last = e;
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check({tag, ".wr"},   64'(o_wr),         64'(e.wr));
        check({tag, ".rd"},   64'(o_rd),         64'(e.rd));
        check({tag, ".data"}, 64'(o_write_data), 64'(e.data));
        check({tag, ".src"},  64'(o_src),        64'(e.src));
    endtask

    initial begin
        last       = '0;
        rst        = 1'b1;
        i_hold     = 1'b0;
        i_p0_valid = 1'b1;
        i_p0_rd    = 5'd3;
        i_p0_data  = 32'hAAAA0003;
        i_p1_valid = 1'b1;
        i_p1_rd    = 5'd4;
        i_p1_data  = 32'hBBBB0004;

        // 1. Reset with both ports requesting
        cycle("rst0", 1'b0, 1'b0);
        cycle("rst1", 1'b0, 1'b0);
        rst = 1'b0;
        cycle("rst_first", 1'b0, 1'b1);
        i_p0_valid = 1'b0;
        i_p1_valid = 1'b0;
        cycle("idle_a", 1'b0, 1'b0);

        // 2. Single port 0 request
        i_p0_valid = 1'b1;
        i_p0_rd    = 5'd5;
        i_p0_data  = 32'hDEADBEEF;
        cycle("p0_only", 1'b1, 1'b0);
        i_p0_valid = 1'b0;
        cycle("p0_after", 1'b0, 1'b0);

        // 3. Contention: grant pattern 1,1,1,0 repeating
        i_p0_valid = 1'b1;
        i_p0_rd    = 5'd10;
        i_p0_data  = $urandom;
        i_p1_valid = 1'b1;
        i_p1_rd    = 5'd11;
        i_p1_data  = $urandom;
        for (int i = 0; i < 8; i++) begin
            if (i % 4 == 3) begin
                cycle("contend", 1'b1, 1'b0);
                i_p0_data = $urandom;
            end else begin
                cycle("contend", 1'b0, 1'b1);
                i_p1_data = $urandom;
            end
        end
        i_p0_valid = 1'b0;
        i_p1_valid = 1'b0;
        cycle("idle_b", 1'b0, 1'b0);

        // 4. Write to x0 is accepted but does not assert o_wr
        i_p1_valid = 1'b1;
        i_p1_rd    = 5'd0;
        i_p1_data  = 32'h12345678;
        cycle("x0", 1'b0, 1'b1);
        i_p1_valid = 1'b0;
        cycle("idle_c", 1'b0, 1'b0);

        // 5. Hold freezes grants and the starvation count
        i_p0_valid = 1'b1;
        i_p0_rd    = 5'd12;
        i_p0_data  = 32'hC0DE0012;
        i_p1_valid = 1'b1;
        i_p1_rd    = 5'd13;
        i_p1_data  = 32'h0BAD0013;
        cycle("pre_hold0", 1'b0, 1'b1);
        i_p1_data = 32'h0BAD1013;
        cycle("pre_hold1", 1'b0, 1'b1);
        i_p1_data = 32'h0BAD2013;
        i_hold = 1'b1;
        for (int i = 0; i < 3; i++)
            cycle("hold", 1'b0, 1'b0);
        i_hold = 1'b0;
        cycle("post_hold_p1", 1'b0, 1'b1);
        i_p1_data = 32'h0BAD3013;
        cycle("post_hold_p0", 1'b1, 1'b0);
        i_p0_valid = 1'b0;
        i_p1_valid = 1'b0;
        cycle("idle_d", 1'b0, 1'b0);

        // 6. Reset arriving alongside a port 0 request
        i_p0_valid = 1'b1;
        i_p0_rd    = 5'd7;
        i_p0_data  = 32'h77777777;
        rst        = 1'b1;
        cycle("rst_mid", 1'b0, 1'b0);
        rst        = 1'b0;
        i_p0_valid = 1'b0;
        cycle("rst_mid_after0", 1'b0, 1'b0);
        cycle("rst_mid_after1", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
